// File: rtl/sa_dma_sequencer_pkg.sv
// Shared constants, state encoding and descriptor payload for the DMA run controller.
package sa_dma_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned LEN_WIDTH      = 32;
  localparam int unsigned AXIL_WIDTH     = 32;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned NUM_CH         = 3;

  localparam logic [REG_AW-1:0] REG_CTRL    = 5'h00;
  localparam logic [REG_AW-1:0] REG_STATUS  = 5'h04;
  localparam logic [REG_AW-1:0] REG_K_ADDR  = 5'h08;
  localparam logic [REG_AW-1:0] REG_K_BYTES = 5'h0C;
  localparam logic [REG_AW-1:0] REG_X_ADDR  = 5'h10;
  localparam logic [REG_AW-1:0] REG_X_BYTES = 5'h14;
  localparam logic [REG_AW-1:0] REG_Y_ADDR  = 5'h18;
  localparam logic [REG_AW-1:0] REG_Y_BYTES = 5'h1C;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT   = 0;
  localparam int unsigned STAT_DONE_BIT   = 1;
  localparam int unsigned STAT_ERR_BIT    = 2;

  localparam int unsigned CH_K = 0;
  localparam int unsigned CH_X = 1;
  localparam int unsigned CH_Y = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]      len;
  } desc_t;

  // Registers are word-aligned; the two low byte-address bits are don't-care.
  function automatic logic [REG_AW-1:0] word_off(input logic [REG_AW-1:0] a);
    return a & ~REG_AW'(3);
  endfunction

endpackage

// File: rtl/sa_dma_sequencer_if.sv
// Register port plus the three DMA descriptor/status channels of the run controller.
interface sa_dma_sequencer_if;

  logic                                                         reg_wr_en;
  logic [sa_dma_pkg::REG_AW-1:0]                                reg_wr_addr;
  logic [sa_dma_pkg::AXIL_WIDTH-1:0]                            reg_wr_data;
  logic                                                         reg_rd_en;
  logic [sa_dma_pkg::REG_AW-1:0]                                reg_rd_addr;
  logic [sa_dma_pkg::AXIL_WIDTH-1:0]                            reg_rd_data;
  logic                                                         reg_rd_valid;
  logic [sa_dma_pkg::NUM_CH-1:0]                                desc_valid;
  logic [sa_dma_pkg::NUM_CH-1:0]                                desc_ready;
  logic [sa_dma_pkg::NUM_CH*sa_dma_pkg::AXI_ADDR_WIDTH-1:0]     desc_addr;
  logic [sa_dma_pkg::NUM_CH*sa_dma_pkg::LEN_WIDTH-1:0]          desc_len;
  logic [sa_dma_pkg::NUM_CH-1:0]                                stat_valid;
  logic [sa_dma_pkg::NUM_CH-1:0]                                stat_error;
  logic                                                         busy;
  logic                                                         irq;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
           desc_ready, stat_valid, stat_error,
    input  reg_rd_data, reg_rd_valid, desc_valid, desc_addr, desc_len, busy, irq
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
           desc_ready, stat_valid, stat_error,
    output reg_rd_data, reg_rd_valid, desc_valid, desc_addr, desc_len, busy, irq
  );

endinterface

// File: rtl/sa_dma_chan_issue.sv
// Per-channel descriptor issue and completion tracking; zero-length channels
// count as issued and complete the moment the job starts.
module sa_dma_chan_issue
  import sa_dma_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  start_i,
  input  logic  active_i,
  input  desc_t desc_i,
  input  logic  desc_ready_i,
  input  logic  stat_valid_i,
  input  logic  stat_error_i,
  output logic  desc_valid_o,
  output logic  issued_c,
  output logic  complete_c,
  output logic  err_c
);

  logic desc_valid_q, desc_valid_d;
  logic issued_q, issued_d;
  logic complete_q, complete_d;
  logic zero_len;
  logic hs;

  assign zero_len = (desc_i.len == '0);
  assign hs       = desc_valid_q & desc_ready_i;

  always_comb begin
    desc_valid_d = desc_valid_q;
    issued_d     = issued_q;
    complete_d   = complete_q;
    if (start_i) begin
      desc_valid_d = ~zero_len;
      issued_d     = zero_len;
      complete_d   = zero_len;
    end else if (active_i) begin
      if (hs) begin
        desc_valid_d = 1'b0;
        issued_d     = 1'b1;
      end
      if (stat_valid_i) begin
        complete_d = 1'b1;
      end
    end else begin
      desc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      desc_valid_q <= 1'b0;
      issued_q     <= 1'b0;
      complete_q   <= 1'b0;
    end else begin
      desc_valid_q <= desc_valid_d;
      issued_q     <= issued_d;
      complete_q   <= complete_d;
    end
  end

  // Look-through terms let the FSM advance in the same cycle as the handshake/status.
  assign issued_c     = issued_q | hs;
  assign complete_c   = complete_q | (active_i & stat_valid_i);
  assign err_c        = active_i & stat_valid_i & stat_error_i;
  assign desc_valid_o = desc_valid_q;

endmodule

// File: rtl/sa_dma_sequencer.sv
// Run controller: job register file, IDLE/ISSUE/WAIT/DONE sequencing of the
// K-read, X-read and Y-write DMA channels, and done/irq reporting.
module sa_dma_sequencer
  import sa_dma_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  sa_dma_sequencer_if.slave bus
);

  state_t                    state_q, state_d;
  logic                      irq_en_q, irq_en_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic                      irq_q, irq_d;
  logic                      rd_valid_q;
  logic [AXIL_WIDTH-1:0]     rd_data_q, rd_data_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q [NUM_CH];
  logic [AXI_ADDR_WIDTH-1:0] addr_d [NUM_CH];
  logic [LEN_WIDTH-1:0]      len_q  [NUM_CH];
  logic [LEN_WIDTH-1:0]      len_d  [NUM_CH];

  logic [REG_AW-1:0]         wr_off, rd_off;
  logic                      idle_c, active_c, start_c;
  logic [NUM_CH-1:0]         issued_c, complete_c, err_c;

  assign wr_off   = word_off(bus.reg_wr_addr);
  assign rd_off   = word_off(bus.reg_rd_addr);
  assign idle_c   = (state_q == IDLE);
  assign active_c = (state_q == ISSUE) || (state_q == WAIT);
  assign start_c  = idle_c && bus.reg_wr_en && (wr_off == REG_CTRL)
                    && bus.reg_wr_data[CTRL_START_BIT];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    desc_t desc_c;
    assign desc_c = '{addr: addr_q[ch], len: len_q[ch]};

    sa_dma_chan_issue u_issue (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_c),
      .active_i     (active_c),
      .desc_i       (desc_c),
      .desc_ready_i (bus.desc_ready[ch]),
      .stat_valid_i (bus.stat_valid[ch]),
      .stat_error_i (bus.stat_error[ch]),
      .desc_valid_o (bus.desc_valid[ch]),
      .issued_c     (issued_c[ch]),
      .complete_c   (complete_c[ch]),
      .err_c        (err_c[ch])
    );

    assign bus.desc_addr[ch*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = addr_q[ch];
    assign bus.desc_len[ch*LEN_WIDTH +: LEN_WIDTH]            = len_q[ch];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_c)        state_d = ISSUE;
      ISSUE:   if (&issued_c)      state_d = WAIT;
      WAIT:    if (&complete_c)    state_d = DONE_ST;
      DONE_ST:                     state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Register writes; job address/length registers are frozen while a job runs.
  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    addr_d   = addr_q;
    len_d    = len_q;
    if (bus.reg_wr_en) begin
      case (wr_off)
        REG_CTRL:    irq_en_d = bus.reg_wr_data[CTRL_IRQ_EN_BIT];
        REG_STATUS: begin
          if (bus.reg_wr_data[STAT_DONE_BIT]) done_d = 1'b0;
          if (bus.reg_wr_data[STAT_ERR_BIT])  err_d  = 1'b0;
        end
        REG_K_ADDR:  if (idle_c) addr_d[CH_K] = AXI_ADDR_WIDTH'(bus.reg_wr_data);
        REG_K_BYTES: if (idle_c) len_d[CH_K]  = LEN_WIDTH'(bus.reg_wr_data);
        REG_X_ADDR:  if (idle_c) addr_d[CH_X] = AXI_ADDR_WIDTH'(bus.reg_wr_data);
        REG_X_BYTES: if (idle_c) len_d[CH_X]  = LEN_WIDTH'(bus.reg_wr_data);
        REG_Y_ADDR:  if (idle_c) addr_d[CH_Y] = AXI_ADDR_WIDTH'(bus.reg_wr_data);
        REG_Y_BYTES: if (idle_c) len_d[CH_Y]  = LEN_WIDTH'(bus.reg_wr_data);
        default: ;
      endcase
    end
    // Hardware sets are applied after software clears so a same-cycle set wins.
    if (start_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (|err_c) begin
      err_d = 1'b1;
    end
    if (state_q == DONE_ST) begin
      done_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
    irq_d  = done_d & irq_en_d;
  end

  // Read mux samples pre-update register values.
  always_comb begin
    rd_data_d = '0;
    case (rd_off)
      REG_CTRL:    rd_data_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      REG_STATUS: begin
        rd_data_d[STAT_BUSY_BIT] = busy_q;
        rd_data_d[STAT_DONE_BIT] = done_q;
        rd_data_d[STAT_ERR_BIT]  = err_q;
      end
      REG_K_ADDR:  rd_data_d = AXIL_WIDTH'(addr_q[CH_K]);
      REG_K_BYTES: rd_data_d = AXIL_WIDTH'(len_q[CH_K]);
      REG_X_ADDR:  rd_data_d = AXIL_WIDTH'(addr_q[CH_X]);
      REG_X_BYTES: rd_data_d = AXIL_WIDTH'(len_q[CH_X]);
      REG_Y_ADDR:  rd_data_d = AXIL_WIDTH'(addr_q[CH_Y]);
      REG_Y_BYTES: rd_data_d = AXIL_WIDTH'(len_q[CH_Y]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
      rd_valid_q <= bus.reg_rd_en;
      if (bus.reg_rd_en) begin
        rd_data_q <= rd_data_d;
      end
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  assign bus.reg_rd_data  = rd_data_q;
  assign bus.reg_rd_valid = rd_valid_q;
  assign bus.busy         = busy_q;
  assign bus.irq          = irq_q;

endmodule
